// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_checker
//  Description : Watches a 3-bit up-counter and verifies that it counts
//                0,1,...,7,0,...  One sample is captured in HUNT. A following
//                sample that continues the sequence moves the checker to
//                LOCKED. While LOCKED, every mismatch is flagged and counted.
//                The observed counter's own reset (cnt_rst) re-seeds the
//                checker directly into LOCKED, predicting 1 next.
//  Ports       : clk       - clock; all state changes on the rising edge
//                reset     - synchronous, active-low
//                en        - sample count_in on this edge
//                count_in  - observed counter value (3 bits)
//                cnt_rst   - observed counter's reset level (active-high)
//                clr_err   - clear err / err_cnt
//                locked    - 1 while the sequence is being tracked
//                err       - sticky mismatch flag
//                err_pulse - one-cycle strobe per mismatch
//                expected  - predicted next count_in
//                wrap_cnt  - verified 7->0 transitions (wraps at 255)
//                err_cnt   - mismatch count (saturates at 255)
//  Revision    : 1.0 - initial release
// ============================================================================
module count_seq_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] count_in,
  input  logic       cnt_rst,
  input  logic       clr_err,
  output logic       locked,
  output logic       err,
  output logic       err_pulse,
  output logic [2:0] expected,
  output logic [7:0] wrap_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic [2:0] w_exp_nx;
  logic [7:0] w_wrap_nx;
  logic [7:0] w_errcnt_nx;
  logic       w_err_nx;
  logic       w_pulse_nx;
  logic [2:0] w_succ;
  logic       w_match;

  // Successor of the sampled value; 3-bit arithmetic gives the 7->0 wrap.
  assign w_succ  = count_in + 3'd1;
  assign w_match = (count_in == expected);

  always_comb begin
    w_state_nx  = r_state;
    w_exp_nx    = expected;
    w_wrap_nx   = wrap_cnt;
    w_errcnt_nx = err_cnt;
    w_err_nx    = err;
    w_pulse_nx  = 1'b0;

    // Clear first, so that a mismatch on the same edge counts from zero
    // and leaves err_cnt at exactly 1.
    if (clr_err) begin
      w_err_nx    = 1'b0;
      w_errcnt_nx = 8'd0;
    end

    if (cnt_rst) begin
      // The observed counter is being reset, so it will present 0 now and
      // 1 next; count_in is meaningless on this cycle.
      w_state_nx = LOCKED;
      w_exp_nx   = 3'd1;
    end else if (en) begin
      w_exp_nx = w_succ;
      case (r_state)
        HUNT: begin
          w_state_nx = CONFIRM;
        end
        CONFIRM: begin
          if (w_match) begin
            w_state_nx = LOCKED;
          end
        end
        LOCKED: begin
          if (w_match) begin
            if (count_in == 3'd0) begin
              w_wrap_nx = wrap_cnt + 8'd1;
            end
          end else begin
            w_pulse_nx  = 1'b1;
            w_err_nx    = 1'b1;
            w_errcnt_nx = (w_errcnt_nx == 8'hFF) ? 8'hFF : w_errcnt_nx + 8'd1;
            w_state_nx  = CONFIRM;
          end
        end
        default: begin
          w_state_nx = CONFIRM;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= HUNT;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      expected  <= 3'd0;
      wrap_cnt  <= 8'd0;
      err_cnt   <= 8'd0;
    end else begin
      r_state   <= w_state_nx;
      locked    <= (w_state_nx == LOCKED);
      err       <= w_err_nx;
      err_pulse <= w_pulse_nx;
      expected  <= w_exp_nx;
      wrap_cnt  <= w_wrap_nx;
      err_cnt   <= w_errcnt_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_seq_checker
//  Description : Self-checking bench for count_seq_checker. A behavioural
//                model tracks "have a previous sample", "tracking" and the
//                predicted value, and is compared with the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [2:0] count_in = 3'd0;
  logic       cnt_rst = 1'b0;
  logic       clr_err = 1'b0;
  logic       locked;
  logic       err;
  logic       err_pulse;
  logic [2:0] expected;
  logic [7:0] wrap_cnt;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  count_seq_checker dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .count_in (count_in),
    .cnt_rst  (cnt_rst),
    .clr_err  (clr_err),
    .locked   (locked),
    .err      (err),
    .err_pulse(err_pulse),
    .expected (expected),
    .wrap_cnt (wrap_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  bit m_seen;   // a previous sample exists to predict from
  bit m_lk;     // sequence verified and being tracked
  int m_pred;
  int m_wraps;
  int m_errs;
  bit m_flag;
  bit m_pulse;

  logic [21:0] dut_v;
  assign dut_v = {locked, err, err_pulse, expected, wrap_cnt, err_cnt};

  function automatic logic [21:0] model_vec();
    logic [2:0] p;
    logic [7:0] w;
    logic [7:0] e;
    p = m_pred[2:0];
    w = m_wraps[7:0];
    e = m_errs[7:0];
    return {m_lk, m_flag, m_pulse, p, w, e};
  endfunction

  task automatic model_step(input bit rst_n, input bit e, input int c,
                            input bit cr, input bit clr);
    m_pulse = 0;
    if (!rst_n) begin
      m_seen = 0; m_lk = 0; m_pred = 0; m_wraps = 0; m_errs = 0; m_flag = 0;
    end else begin
      if (clr) begin
        m_flag = 0;
        m_errs = 0;
      end
      if (cr) begin
        m_lk = 1; m_seen = 1; m_pred = 1;
      end else if (e) begin
        if (m_lk) begin
          if (c == m_pred) begin
            if (c == 0) m_wraps = (m_wraps + 1) % 256;
          end else begin
            m_pulse = 1;
            m_flag  = 1;
            if (m_errs < 255) m_errs = m_errs + 1;
            m_lk = 0;
          end
        end else begin
          if (m_seen && c == m_pred) m_lk = 1;
          m_seen = 1;
        end
        m_pred = (c + 1) % 8;
      end
    end
  endtask

  task automatic drive(input bit rst_n, input bit e, input int c,
                       input bit cr, input bit clr);
    reset    = rst_n;
    en       = e;
    count_in = c[2:0];
    cnt_rst  = cr;
    clr_err  = clr;
    model_step(rst_n, e, c, cr, clr);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, 1, int'($urandom_range(0, 7)), 1, 1);
    drive(0, 1, int'($urandom_range(0, 7)), 0, 0);
    total++;
    if (dut_v !== 22'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", dut_v, 22'd0);
    end
  endtask

  task automatic test_basic_seq();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, i % 8, 0, 0);
      total++;
      if (dut_v !== model_vec()) begin
        bad++;
        $display("FAIL basic_seq[%0d]: got %h want %h", i, dut_v, model_vec());
      end
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL basic_no_err[%0d]: got %b want 0", i, err);
      end
      if (i == 1) begin
        total++;
        if (locked !== 1'b1) begin
          bad++;
          $display("FAIL basic_lock: got %b want 1", locked);
        end
      end
      if (i == 8) begin
        total++;
        if (wrap_cnt !== 8'd1) begin
          bad++;
          $display("FAIL basic_wrap: got %0d want 1", wrap_cnt);
        end
      end
    end
  endtask

  task automatic test_mismatch();
    drive(1, 1, 2, 0, 0);
    drive(1, 1, 3, 0, 0);
    total++;
    if (expected !== 3'd4 || locked !== 1'b1) begin
      bad++;
      $display("FAIL mm_pre: got exp=%0d lk=%b want exp=4 lk=1", expected, locked);
    end
    drive(1, 1, 6, 0, 0);
    total++;
    if (dut_v !== {1'b0, 1'b1, 1'b1, 3'd7, 8'd1, 8'd1}) begin
      bad++;
      $display("FAIL mm_hit: got %h want %h", dut_v, {1'b0, 1'b1, 1'b1, 3'd7, 8'd1, 8'd1});
    end
    drive(1, 1, 7, 0, 0);
    total++;
    if (locked !== 1'b1 || err_pulse !== 1'b0 || expected !== 3'd0 || dut_v !== model_vec()) begin
      bad++;
      $display("FAIL mm_relock: got %h want %h", dut_v, model_vec());
    end
  endtask

  task automatic test_cnt_rst();
    for (int i = 0; i <= 5; i++) drive(1, 1, i, 0, 0);
    drive(1, 1, int'($urandom_range(0, 7)), 1, 0);
    total++;
    if (dut_v !== {1'b1, 1'b1, 1'b0, 3'd1, 8'd2, 8'd1}) begin
      bad++;
      $display("FAIL cntrst_hit: got %h want %h", dut_v, {1'b1, 1'b1, 1'b0, 3'd1, 8'd2, 8'd1});
    end
    drive(1, 1, 1, 0, 0);
    total++;
    if (dut_v !== {1'b1, 1'b1, 1'b0, 3'd2, 8'd2, 8'd1}) begin
      bad++;
      $display("FAIL cntrst_1: got %h want %h", dut_v, {1'b1, 1'b1, 1'b0, 3'd2, 8'd2, 8'd1});
    end
    drive(1, 1, 2, 0, 0);
    total++;
    if (dut_v !== {1'b1, 1'b1, 1'b0, 3'd3, 8'd2, 8'd1} || dut_v !== model_vec()) begin
      bad++;
      $display("FAIL cntrst_2: got %h want %h", dut_v, model_vec());
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      drive(1, 1, (m_pred + 1 + int'($urandom_range(0, 6))) % 8, 0, 0);
      total++;
      if (dut_v !== model_vec() || err_pulse !== 1'b1) begin
        bad++;
        $display("FAIL sat_mm[%0d]: got %h want %h", i, dut_v, model_vec());
      end
      drive(1, 1, m_pred, 0, 0);
      total++;
      if (dut_v !== model_vec() || locked !== 1'b1) begin
        bad++;
        $display("FAIL sat_relock[%0d]: got %h want %h", i, dut_v, model_vec());
      end
    end
    total++;
    if (err_cnt !== 8'd255) begin
      bad++;
      $display("FAIL sat_value: got %0d want 255", err_cnt);
    end
    drive(1, 0, int'($urandom_range(0, 7)), 0, 1);
    total++;
    if (err !== 1'b0 || err_cnt !== 8'd0 || locked !== 1'b1) begin
      bad++;
      $display("FAIL sat_clear: got err=%b cnt=%0d lk=%b want 0 0 1", err, err_cnt, locked);
    end
  endtask

  task automatic test_clr_collision();
    drive(1, 1, (m_pred + 4) % 8, 0, 1);
    total++;
    if (err !== 1'b1 || err_cnt !== 8'd1 || err_pulse !== 1'b1 || dut_v !== model_vec()) begin
      bad++;
      $display("FAIL clr_coll: got %h want %h", dut_v, model_vec());
    end
    drive(1, 1, m_pred, 0, 0);
    total++;
    if (err_pulse !== 1'b0 || locked !== 1'b1) begin
      bad++;
      $display("FAIL clr_coll_after: got pulse=%b lk=%b want 0 1", err_pulse, locked);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, int'($urandom_range(0, 7)), 0, 0);
      total++;
      if (dut_v !== model_vec() || locked !== 1'b1) begin
        bad++;
        $display("FAIL hold[%0d]: got %h want %h", i, dut_v, model_vec());
      end
    end
    drive(1, 1, m_pred, 0, 0);
    total++;
    if (locked !== 1'b1 || err_pulse !== 1'b0 || dut_v !== model_vec()) begin
      bad++;
      $display("FAIL hold_resume: got %h want %h", dut_v, model_vec());
    end
  endtask

  task automatic test_reset_midlock();
    drive(0, 1, int'($urandom_range(0, 7)), 1, 1);
    total++;
    if (dut_v !== 22'd0) begin
      bad++;
      $display("FAIL rst_mid: got %h want %h", dut_v, 22'd0);
    end
    drive(1, 1, 5, 0, 0);
    total++;
    if (locked !== 1'b0 || expected !== 3'd6) begin
      bad++;
      $display("FAIL rst_capture: got lk=%b exp=%0d want 0 6", locked, expected);
    end
    drive(1, 1, 6, 0, 0);
    total++;
    if (locked !== 1'b1 || expected !== 3'd7) begin
      bad++;
      $display("FAIL rst_relock: got lk=%b exp=%0d want 1 7", locked, expected);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit r, e, cr, clr;
      int c;
      r   = ($urandom_range(0, 99) != 0);
      e   = ($urandom_range(0, 3) != 0);
      cr  = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 19) == 0);
      c   = ($urandom_range(0, 9) < 8) ? m_pred : int'($urandom_range(0, 7));
      drive(r, e, c, cr, clr);
      total++;
      if (dut_v !== model_vec()) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, dut_v, model_vec());
      end
    end
  endtask

  initial begin
    m_seen = 0; m_lk = 0; m_pred = 0; m_wraps = 0; m_errs = 0; m_flag = 0; m_pulse = 0;
    #2;
    test_reset();
    test_basic_seq();
    test_mismatch();
    test_cnt_rst();
    test_saturation();
    test_clr_collision();
    test_hold();
    test_reset_midlock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_seq_checker.md
COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

Interface
REQ-001 The block SHALL have ports `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port `reset`, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
REQ-003 The block SHALL have port `en`, input, 1 bit: when 1, `count_in` is sampled this edge.
REQ-004 The block SHALL have port `count_in`, input, 3 bits: value produced by the observed 3-bit up-counter.
REQ-005 The block SHALL have port `cnt_rst`, input, 1 bit: the observed counter's active-high reset, delivered as a level.
REQ-006 The block SHALL have port `clr_err`, input, 1 bit: clears `err` and `err_cnt`.
REQ-007 The block SHALL have port `locked`, output, 1 bit: the sequence is verified and being tracked.
REQ-008 The block SHALL have port `err`, output, 1 bit: sticky flag, set on any mismatch while locked.
REQ-009 The block SHALL have port `err_pulse`, output, 1 bit: high for exactly one cycle per mismatch.
REQ-010 The block SHALL have port `expected`, output, 3 bits: next value the checker predicts.
REQ-011 The block SHALL have port `wrap_cnt`, output, 8 bits: number of 7->0 transitions verified while locked.
REQ-012 The block SHALL have port `err_cnt`, output, 8 bits: mismatch count, saturating.

Function
REQ-013 The block SHALL implement three states: HUNT, CONFIRM and LOCKED; `locked` SHALL be 1 only in LOCKED.
REQ-014 All outputs SHALL be registered and SHALL reflect the sample taken at edge N immediately after edge N (one-cycle latency).
REQ-015 The block SHALL hold all state when `en` is 0, except for the effects of `reset`, `cnt_rst` and `clr_err`.
REQ-016 In HUNT, with `en`=1 and `cnt_rst`=0, the block SHALL set `expected` to `count_in`+1 modulo 8 and move to CONFIRM.
REQ-017 In CONFIRM, with `en`=1: if `count_in`==`expected`, the block SHALL move to LOCKED and set `expected` to `count_in`+1 modulo 8.
REQ-018 In CONFIRM, with `en`=1 and `count_in`!=`expected`, the block SHALL stay in CONFIRM, set `expected` to `count_in`+1 modulo 8, and raise no error.
REQ-019 In LOCKED, with `en`=1 and `count_in`==`expected`, the block SHALL set `expected` to `count_in`+1 modulo 8.
REQ-020 In LOCKED, with `en`=1, `count_in`==`expected` and `count_in`==0, the block SHALL increment `wrap_cnt`, wrapping 255->0.
REQ-021 In LOCKED, with `en`=1 and `count_in`!=`expected`, the block SHALL assert `err_pulse` for one cycle.
REQ-022 On the same mismatch as REQ-021, the block SHALL set `err` to 1.
REQ-023 On the same mismatch as REQ-021, the block SHALL increment `err_cnt`, saturating at 255.
REQ-024 On the same mismatch as REQ-021, the block SHALL set `expected` to `count_in`+1 modulo 8 and move to CONFIRM.
REQ-025 When `cnt_rst`=1 (regardless of `en`), the block SHALL move to LOCKED with `expected`=1 and raise no error.
REQ-026 `wrap_cnt`, `err` and `err_cnt` SHALL be preserved across `cnt_rst`.
REQ-027 The block SHALL treat `count_in` as 0 on any `cnt_rst` cycle; `count_in` SHALL be ignored on that cycle.
REQ-028 `clr_err`=1 SHALL clear `err` and `err_cnt` on that edge.
REQ-029 If `clr_err` coincides with a mismatch, the mismatch SHALL win: `err`=1, `err_cnt`=1, `err_pulse`=1.
REQ-030 `cnt_rst` SHALL take priority over any `en` sample on the same edge.
REQ-031 `err_pulse` SHALL be 0 on every cycle without a LOCKED-state mismatch.

Reset
REQ-032 When `reset`=0 at a rising edge, the block SHALL enter HUNT with `locked`=0, `err`=0, `err_pulse`=0, `expected`=0, `wrap_cnt`=0 and `err_cnt`=0.
REQ-033 `reset` SHALL override `cnt_rst`, `clr_err` and `en`.
REQ-034 Reset asserted mid-sequence SHALL discard all tracking, including the lock.
REQ-035 After release, the first `en` sample SHALL be treated as the HUNT capture.

Verification
REQ-036 Reset then `en`=1 with count 0,1,...,7,0,1: `locked`=1 after the second sample; `wrap_cnt`=1 after the 0 following 7; `err`=0 throughout.
REQ-037 While locked at `expected`=4, drive 6: `err_pulse`=1 for one cycle, `err`=1, `err_cnt`=1, state CONFIRM, `expected`=7; then drive 7 -> `locked`=1.
REQ-038 While locked at count 5, assert `cnt_rst` for one cycle, then drive 1,2: no error; `expected`=1 and then 2; `locked` stays 1; `wrap_cnt` unchanged.
REQ-039 Force 256 consecutive mismatches, alternating lock and break: `err_cnt` saturates at 255; then `clr_err`: `err`=0, `err_cnt`=0.
REQ-040 Assert `clr_err` on the same edge as a mismatch: `err`=1, `err_cnt`=1.
REQ-041 With `en`=0 for 10 cycles mid-lock: no state or output change; then with `en`=1 and the next expected value: still locked, no error.
REQ-042 Assert `reset`=0 mid-lock together with `cnt_rst`=1: all outputs return to their reset values and the state is HUNT.
